// File: rtl/tl_d_resp_queue.sv
// -----------------------------------------------------------------------------
// tl_d_resp_queue
//   Registered circular buffer for TileLink D-channel beats, placed between the
//   slave-side responder and the port monitor. It also keeps a per-source
//   in-flight tracker fed by the A channel and raises two sticky protocol flags:
//     err_unexpected : a D beat was queued for a source that had no request
//     err_reuse      : an A request reused a source that was still in flight
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   a_fire, a_source        A-channel handshake observed and its source ID
//   enq_valid / enq_ready   D beat from the responder into the queue
//   enq_*                   D beat fields (opcode, param, size, source, sink,
//                           denied, data, corrupt)
//   deq_valid / deq_ready   head beat towards the consumer
//   deq_*                   head beat fields
//   count                   number of occupied entries
//   inflight                one bit per outstanding source ID
//   err_unexpected          sticky, see above
//   err_reuse               sticky, see above
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. enq_ready and deq_valid are functions of registered state only, so a
// dequeue in the same cycle never opens a full queue, and a newly written
// entry is first visible on deq_* one cycle after its enqueue.
// -----------------------------------------------------------------------------
module tl_d_resp_queue #(
    parameter int DEPTH       = 2,
    parameter int SOURCE_BITS = 5,
    parameter int BEAT_BYTES  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          a_fire,
    input  logic [SOURCE_BITS-1:0]        a_source,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [2:0]                    enq_opcode,
    input  logic [1:0]                    enq_param,
    input  logic [2:0]                    enq_size,
    input  logic [SOURCE_BITS-1:0]        enq_source,
    input  logic                          enq_sink,
    input  logic                          enq_denied,
    input  logic [31:0]                   enq_data,
    input  logic                          enq_corrupt,
    output logic                          deq_valid,
    input  logic                          deq_ready,
    output logic [2:0]                    deq_opcode,
    output logic [1:0]                    deq_param,
    output logic [2:0]                    deq_size,
    output logic [SOURCE_BITS-1:0]        deq_source,
    output logic                          deq_sink,
    output logic                          deq_denied,
    output logic [31:0]                   deq_data,
    output logic                          deq_corrupt,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [(1<<SOURCE_BITS)-1:0]   inflight,
    output logic                          err_unexpected,
    output logic                          err_reuse
);

    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH+1);
    localparam int NUM_SRC    = 1 << SOURCE_BITS;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [8:0]       BEAT_BYTES_V = 9'(BEAT_BYTES);
    localparam logic [CNT_W-1:0] DEPTH_V      = CNT_W'(DEPTH);
    localparam logic [2:0]       OP_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [1:0]             param;
        logic [2:0]             size;
        logic [SOURCE_BITS-1:0] source;
        logic                   sink;
        logic                   denied;
        logic [31:0]            data;
        logic                   corrupt;
    } beat_t;

    beat_t            mem [DEPTH];
    beat_t            head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       beat_cnt;

    logic             enq_fire;
    logic             deq_fire;
    logic [8:0]       head_bytes;
    logic [7:0]       beats_m1;
    logic             beat_last;
    logic             clr_fire;
    logic             clr_hits_a;
    logic [NUM_SRC-1:0] set_mask;
    logic [NUM_SRC-1:0] clr_mask;

    assign enq_ready = (count != DEPTH_V);
    assign deq_valid = (count != '0);
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    assign head        = mem[rd_ptr];
    assign deq_opcode  = head.opcode;
    assign deq_param   = head.param;
    assign deq_size    = head.size;
    assign deq_source  = head.source;
    assign deq_sink    = head.sink;
    assign deq_denied  = head.denied;
    assign deq_data    = head.data;
    assign deq_corrupt = head.corrupt;

    // Only AccessAckData bursts span several beats; a response no wider than
    // the bus is still a single beat.
    always_comb begin
        head_bytes = 9'd1 << head.size;
        beats_m1   = '0;
        if (head.opcode == OP_ACCESS_ACK_DATA && head_bytes > BEAT_BYTES_V) begin
            beats_m1 = 8'((head_bytes >> BEAT_SHIFT) - 9'd1);
        end
    end

    assign beat_last  = (beat_cnt == beats_m1);
    assign clr_fire   = deq_fire & beat_last;
    assign clr_hits_a = clr_fire & (head.source == a_source);

    // Set is applied after clear so a source retired and reissued in the same
    // cycle stays in flight.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (a_fire)   set_mask[a_source]    = 1'b1;
        if (clr_fire) clr_mask[head.source] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (enq_fire) begin
            mem[wr_ptr] <= '{opcode:  enq_opcode,
                             param:   enq_param,
                             size:    enq_size,
                             source:  enq_source,
                             sink:    enq_sink,
                             denied:  enq_denied,
                             data:    enq_data,
                             corrupt: enq_corrupt};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            beat_cnt       <= '0;
            inflight       <= '0;
            err_unexpected <= 1'b0;
            err_reuse      <= 1'b0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);

            if (enq_fire && !deq_fire)      count <= count + CNT_W'(1);
            else if (!enq_fire && deq_fire) count <= count - CNT_W'(1);

            if (deq_fire) beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;

            inflight <= (inflight & ~clr_mask) | set_mask;

            if (a_fire && inflight[a_source] && !clr_hits_a)
                err_reuse <= 1'b1;

            // A request issued in the same cycle legitimises the response.
            if (enq_fire && !inflight[enq_source] &&
                !(a_fire && a_source == enq_source))
                err_unexpected <= 1'b1;
        end
    end

endmodule
